// File: rtl/replay_bar_ctrl.sv
// replay_bar_ctrl
//   Sequencer for the game-over "REPLAY?" screen. A game_over pulse opens the
//   screen; once the confirm button has been released the four-segment bar
//   fills one segment every SEG_FRAMES frame ticks. A button press while the
//   bar fills issues replay_req. A bar that has stayed full for one more
//   segment period issues exit_req.
//
//   Optional feature macro: REPLAY_BLINK_EN
//     When defined, the "REPLAY?" text blinks while the bar fills. It toggles
//     every BLINK_FRAMES ticks. When undefined, text_visible is constant 1.
//
// Parameters
//   SEG_FRAMES    frame ticks per bar segment (>= 1)
//   BLINK_FRAMES  frame ticks per text blink half-period (>= 1)
//
// Ports
//   clk            system clock
//   rst            synchronous active-high reset
//   frame_tick     one-cycle pulse per display frame
//   game_over      one-cycle pulse from the game FSM
//   btn_confirm    debounced confirm button level
//   screen_active  replay screen shown (ARM, COUNT, EXPIRE)
//   segs_lit       lit bar segments, 0..4
//   text_visible   "REPLAY?" text enable
//   replay_req     one-cycle pulse: restart the game
//   exit_req       one-cycle pulse: return to the menu
module replay_bar_ctrl #(
    parameter int SEG_FRAMES   = 30,
    parameter int BLINK_FRAMES = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       game_over,
    input  logic       btn_confirm,
    output logic       screen_active,
    output logic [2:0] segs_lit,
    output logic       text_visible,
    output logic       replay_req,
    output logic       exit_req
);

    if (SEG_FRAMES < 1) begin : g_bad_seg_frames
        $error("replay_bar_ctrl: SEG_FRAMES must be at least 1");
    end
    if (BLINK_FRAMES < 1) begin : g_bad_blink_frames
        $error("replay_bar_ctrl: BLINK_FRAMES must be at least 1");
    end

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        COUNT,
        EXPIRE
    } state_t;

    localparam int            FW       = $clog2(SEG_FRAMES + 1);
    localparam logic [FW-1:0] SEG_LAST = FW'(SEG_FRAMES - 1);

    state_t        state, state_nxt;
    logic          btn_q;
    logic          rise;
    logic [FW-1:0] frame_cnt, frame_cnt_nxt;
    logic [2:0]    segs_nxt;
    logic          replay_nxt, exit_nxt;

    assign rise = btn_confirm & ~btn_q;

    // NOTE: every variable gets a default before the case so that no path
    // leaves it unassigned. This keeps the block purely combinational.
    always_comb begin
        state_nxt     = state;
        frame_cnt_nxt = frame_cnt;
        segs_nxt      = segs_lit;
        replay_nxt    = 1'b0;
        exit_nxt      = 1'b0;
        case (state)
            IDLE: begin
                segs_nxt = 3'd0;
                if (game_over) begin
                    state_nxt     = ARM;
                    frame_cnt_nxt = '0;
                end
            end
            ARM: begin
                // A button held over from gameplay must first be released.
                if (frame_tick && !btn_confirm) begin
                    state_nxt = COUNT;
                end
            end
            COUNT: begin
                // A confirm takes priority over an expiring tick in the same cycle.
                if (rise) begin
                    state_nxt  = IDLE;
                    replay_nxt = 1'b1;
                    segs_nxt   = 3'd0;
                end else if (frame_tick) begin
                    if (frame_cnt == SEG_LAST) begin
                        frame_cnt_nxt = '0;
                        // A full bar stays on screen for one more period before expiry.
                        if (segs_lit == 3'd4) begin
                            state_nxt = EXPIRE;
                            exit_nxt  = 1'b1;
                        end else begin
                            segs_nxt = segs_lit + 3'd1;
                        end
                    end else begin
                        frame_cnt_nxt = frame_cnt + FW'(1);
                    end
                end
            end
            EXPIRE: begin
                state_nxt = IDLE;
                segs_nxt  = 3'd0;
            end
            default: begin
                state_nxt = IDLE;
                segs_nxt  = 3'd0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments. Every register
    // then samples the pre-edge values of the other registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            // NOTE: btn_q resets high. A button held through reset then never looks like a rise.
            btn_q         <= 1'b1;
            frame_cnt     <= '0;
            segs_lit      <= 3'd0;
            screen_active <= 1'b0;
            replay_req    <= 1'b0;
            exit_req      <= 1'b0;
        end else begin
            state         <= state_nxt;
            btn_q         <= btn_confirm;
            frame_cnt     <= frame_cnt_nxt;
            segs_lit      <= segs_nxt;
            screen_active <= (state_nxt != IDLE);
            replay_req    <= replay_nxt;
            exit_req      <= exit_nxt;
        end
    end

`ifdef REPLAY_BLINK_EN
    localparam int            BW         = $clog2(BLINK_FRAMES + 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

    logic [BW-1:0] blink_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            blink_cnt    <= '0;
            text_visible <= 1'b1;
        end else begin
            // The text is forced back on whenever the bar is not filling next cycle.
            if (state_nxt != COUNT) begin
                text_visible <= 1'b1;
            end
            if (state == IDLE && game_over) begin
                blink_cnt <= '0;
            end else if (state == COUNT && state_nxt == COUNT && frame_tick) begin
                if (blink_cnt == BLINK_LAST) begin
                    blink_cnt    <= '0;
                    text_visible <= ~text_visible;
                end else begin
                    blink_cnt <= blink_cnt + BW'(1);
                end
            end
        end
    end
`else
    assign text_visible = 1'b1;
`endif

endmodule

// File: doc/replay_bar_ctrl.md
# replay_bar_ctrl

Sequencer for the game-over "REPLAY?" screen: after a game-over pulse it fills the four-segment loading bar one segment per fixed number of frames and waits for the player to confirm. It issues a one-cycle replay request on confirm or an exit request when the bar expires. It sits between the game FSM, the debounced button, and the screen pixel logic, which consumes `segs_lit` and `text_visible`.

## Interface
- `SEG_FRAMES`, default 30: frame ticks per bar segment; must be at least 1.
- `BLINK_FRAMES`, default 15: frame ticks per "REPLAY?" text blink half-period; must be at least 1.
- `clk`  in  1  system clock.
- `rst`  in  1  reset; synchronous and active-high.
- `frame_tick`  in  1  one-cycle pulse, once per display frame.
- `game_over`  in  1  one-cycle pulse from the game FSM.
- `btn_confirm`  in  1  debounced button level.
- `screen_active`  out  1  high while the replay screen must be shown.
- `segs_lit`  out  3  lit bar segments, range 0..4 (left to right).
- `text_visible`  out  1  "REPLAY?" text enable.
- `replay_req`  out  1  one-cycle pulse: restart game.
- `exit_req`  out  1  one-cycle pulse: return to menu.

## Operation
- States:
  - IDLE
  - ARM: wait for button release.
  - COUNT: bar filling.
  - EXPIRE: one cycle, pulses `exit_req`.
- Internal registers:
  - `btn_q`: `btn_confirm` delayed one cycle. A rising edge (`rise`) is `btn_confirm & ~btn_q`.
  - `frame_cnt`: width $clog2(SEG_FRAMES+1).
  - `blink_cnt`: width $clog2(BLINK_FRAMES+1).
- IDLE: on `game_over` go to ARM and clear `segs_lit`, `frame_cnt`, `blink_cnt`. Set `text_visible` to 1.
- ARM: on a cycle with `frame_tick` and `btn_confirm`=0, go to COUNT. A button held from gameplay never counts as confirm.
- COUNT:
  - On `frame_tick`: if `frame_cnt` == SEG_FRAMES-1, set `frame_cnt` to 0 and do the expiry/segment step below. Otherwise increment `frame_cnt`.
  - Expiry/segment step: if `segs_lit` == 4, go to EXPIRE. Otherwise increment `segs_lit`.
  - The bar shows 4 segments for one full SEG_FRAMES period before expiry.
  - On `rise`: pulse `replay_req`, go to IDLE.
- EXPIRE: pulse `exit_req`, go to IDLE next cycle.
- `screen_active` = 1 in ARM, COUNT and EXPIRE; 0 in IDLE.
- In IDLE, `segs_lit` holds 0 and `text_visible` holds 1.

## Timing
- Reset values: state IDLE, `btn_q`=1, `screen_active`=0, `segs_lit`=0, `text_visible`=1, `replay_req`=0, `exit_req`=0.
- `btn_q` resets to 1 so that a button held through reset never produces a rise.
- All outputs are registered.
- `game_over` sampled at edge N gives `screen_active`=1 from N+1.
- `rise` at edge N gives `replay_req`=1 during cycle N+1 only, with `screen_active`=0 from N+1.
- Total expiry time from entering COUNT: 5*SEG_FRAMES frame ticks. `exit_req` is high for exactly 1 cycle, the cycle after the expiring tick.
- Simultaneous `rise` and expiring `frame_tick` in COUNT: confirm wins. `replay_req` pulses and `exit_req` does not.
- `game_over` outside IDLE is ignored. No re-arm and no counter clear.
- `rst` mid-operation forces the reset values on the next edge. A pending pulse is dropped.
- `frame_tick` and `rise` in ARM: only the release condition is evaluated; no request is issued.
- `segs_lit` never exceeds 4; there is no wrap-around.

## Configuration
- `REPLAY_BLINK_EN` defined:
  - In COUNT, each `frame_tick` increments `blink_cnt`.
  - When `blink_cnt` reaches BLINK_FRAMES-1, it clears and `text_visible` toggles.
  - `text_visible` forces to 1 on leaving COUNT.
- `REPLAY_BLINK_EN` not defined: `blink_cnt` is not instantiated and `text_visible` is constant 1.

## Test plan
- Reset with `btn_confirm`=1, SEG_FRAMES=2, `game_over` pulse, button held 3 ticks then released -> state stays ARM, `segs_lit`=0, no `replay_req`; COUNT entered on the first tick with the button low.
- SEG_FRAMES=2, no button press -> `segs_lit` steps 1,2,3,4 every 2 ticks, then after 2 more ticks `exit_req` is high for 1 cycle, and `screen_active` is 0 on the following cycle.
- Button rise while `segs_lit`=2 -> `replay_req` is a single 1-cycle pulse, `segs_lit`=0, `screen_active`=0, `exit_req` never asserted.
- Button rise on the same cycle as the expiring tick at `segs_lit`=4 -> only `replay_req` pulses.
- `rst` asserted during COUNT with `segs_lit`=3 -> next cycle all outputs are at their reset values; a second `game_over` while in COUNT, with no reset, leaves `segs_lit` unchanged.
- Build with `REPLAY_BLINK_EN`, BLINK_FRAMES=3 -> `text_visible` toggles every 3 ticks in COUNT and is 1 in IDLE. Without the macro -> `text_visible` is constant 1.
